// File: rtl/sobel_window_scheduler_if.sv
// Bundles the pixel-memory read port, the multiplier feed/return and the result stream.
// Master is the scheduler; slave is the memory/multiplier/downstream side.
interface sobel_window_scheduler_if #(
    parameter int ADDR_W = 24
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [23:0]       mem_rd_data;
    logic [23:0]       hold_a;
    logic [23:0]       hold_b;
    logic [23:0]       hold_c;
    logic              mult_en;
    // Gradients are carried as raw 9-bit two's-complement patterns.
    logic [8:0]        sobel_x_in;
    logic [8:0]        sobel_y_in;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_addr;
    logic [8:0]        res_x;
    logic [8:0]        res_y;

    modport master (
        output mem_rd_en, mem_rd_addr, hold_a, hold_b, hold_c, mult_en,
               res_valid, res_addr, res_x, res_y,
        input  mem_rd_data, sobel_x_in, sobel_y_in, res_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, hold_a, hold_b, hold_c, mult_en,
               res_valid, res_addr, res_x, res_y,
        output mem_rd_data, sobel_x_in, sobel_y_in, res_ready
    );
endinterface

// File: rtl/sobel_window_scheduler.sv
// Per-pixel Sobel sequencer: 3 row reads, MULT_LAT+1 feed cycles, one result; 8 cycles/pixel at default.
// Backpressure: the result is held in OUT until res_ready; no new reads are issued while stalled.
module sobel_window_scheduler #(
    parameter int unsigned START_ADDR = 770,
    parameter int unsigned END_ADDR   = 1048576,
    parameter int unsigned IMG_W      = 768,
    parameter int          ADDR_W     = 24,
    parameter int unsigned MULT_LAT   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    sobel_window_scheduler_if.master bus
);
    localparam int CNT_W = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;
    localparam logic [ADDR_W-1:0] FIRST_PIX = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(END_ADDR - 1);
    localparam logic [ADDR_W-1:0] ROW_OFS   = ADDR_W'(IMG_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MULT_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_CAPT, S_FEED, S_OUT, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       hold_a_q, hold_a_d, hold_b_q, hold_b_d, hold_c_q, hold_c_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [8:0]        res_x_q, res_x_d, res_y_q, res_y_d;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mult_en;
    logic              res_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pix_q      <= FIRST_PIX;
            cnt_q      <= '0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
            hold_c_q   <= '0;
            res_addr_q <= '0;
            res_x_q    <= '0;
            res_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            cnt_q      <= cnt_d;
            hold_a_q   <= hold_a_d;
            hold_b_q   <= hold_b_d;
            hold_c_q   <= hold_c_d;
            res_addr_q <= res_addr_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        cnt_d      = cnt_q;
        hold_a_d   = hold_a_q;
        hold_b_d   = hold_b_q;
        hold_c_d   = hold_c_q;
        res_addr_d = res_addr_q;
        res_x_d    = res_x_q;
        res_y_d    = res_y_q;
        rd_en      = 1'b0;
        rd_addr    = '0;
        mult_en    = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pix_d   = FIRST_PIX;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                rd_en   = 1'b1;
                rd_addr = pix_q - ROW_OFS;
                state_d = S_RD_B;
            end
            // Read data lags its address by one cycle, so each row lands one state later.
            S_RD_B: begin
                rd_en    = 1'b1;
                rd_addr  = pix_q;
                hold_a_d = bus.mem_rd_data;
                state_d  = S_RD_C;
            end
            S_RD_C: begin
                rd_en    = 1'b1;
                rd_addr  = pix_q + ROW_OFS;
                hold_b_d = bus.mem_rd_data;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                hold_c_d = bus.mem_rd_data;
                cnt_d    = '0;
                state_d  = S_FEED;
            end
            S_FEED: begin
                mult_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_x_d    = bus.sobel_x_in;
                    res_y_d    = bus.sobel_y_in;
                    res_addr_d = pix_q;
                    state_d    = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    if (pix_q == LAST_PIX) begin
                        state_d = S_FIN;
                    end else begin
                        pix_d   = pix_q + ADDR_W'(1);
                        state_d = S_RD_A;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.hold_a      = hold_a_q;
    assign bus.hold_b      = hold_b_q;
    assign bus.hold_c      = hold_c_q;
    assign bus.mult_en     = mult_en;
    assign bus.res_valid   = res_valid;
    assign bus.res_addr    = res_addr_q;
    assign bus.res_x       = res_x_q;
    assign bus.res_y       = res_y_q;
endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Bench for sobel_window_scheduler: pixel RAM and 2-stage Sobel multiplier models, result/address scoreboards.
module tb_sobel_window_scheduler;
    localparam int START = 770;
    localparam int END_A = 773;
    localparam int IMGW  = 768;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    sobel_window_scheduler_if #(.ADDR_W(24)) bus ();

    sobel_window_scheduler #(
        .START_ADDR(START), .END_ADDR(END_A), .IMG_W(IMGW), .ADDR_W(24), .MULT_LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int done_cnt = 0;
    int last_hs_cyc = -100;
    int prev_hs = -1;
    bit gap_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel RAM: mode 0 replicates the address low byte, mode 1 returns one fixed word per row band.
    int          mem_mode = 0;
    logic [23:0] row_a = '0, row_b = '0, row_c = '0;
    logic [23:0] rd_data_r = '0;

    function automatic logic [23:0] mem_word(input logic [23:0] a);
        if (mem_mode == 0) return {a[7:0], a[7:0], a[7:0]};
        if (a < 24'(START)) return row_a;
        if (a >= 24'(START + IMGW)) return row_c;
        return row_b;
    endfunction

    always @(posedge clk) if (bus.mem_rd_en) rd_data_r <= mem_word(bus.mem_rd_addr);
    assign bus.mem_rd_data = rd_data_r;

    function automatic logic [8:0] grad_x(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        int v;
        v = (int'(a[7:0]) + 2 * int'(b[7:0]) + int'(c[7:0]))
          - (int'(a[23:16]) + 2 * int'(b[23:16]) + int'(c[23:16]));
        return 9'(v);
    endfunction

    function automatic logic [8:0] grad_y(input logic [23:0] a, input logic [23:0] c);
        int v;
        v = (int'(c[23:16]) + 2 * int'(c[15:8]) + int'(c[7:0]))
          - (int'(a[23:16]) + 2 * int'(a[15:8]) + int'(a[7:0]));
        return 9'(v);
    endfunction

    logic [8:0] s1x = '0, s1y = '0, s2x = '0, s2y = '0;
    always @(posedge clk) begin
        if (!bus.mult_en) begin
            s1x <= '0; s1y <= '0; s2x <= '0; s2y <= '0;
        end else begin
            s1x <= grad_x(bus.hold_a, bus.hold_b, bus.hold_c);
            s1y <= grad_y(bus.hold_a, bus.hold_c);
            s2x <= s1x;
            s2y <= s1y;
        end
    end
    assign bus.sobel_x_in = s2x;
    assign bus.sobel_y_in = s2y;

    typedef struct packed {
        logic [23:0] addr;
        logic [8:0]  x;
        logic [8:0]  y;
    } res_t;
    res_t        exp_q[$];
    logic [23:0] addr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops both scoreboards as the DUT presents reads and results.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_rd_en) begin
                if (addr_q.size() == 0) chk("rd_unexpected", 32'(addr_q.size()), 1);
                else chk("rd_addr", 32'(bus.mem_rd_addr), 32'(addr_q.pop_front()));
            end
            if (bus.res_valid && bus.res_ready) begin
                res_t e;
                hs_count++;
                if (gap_chk && prev_hs >= 0) chk("res_gap", 32'(cyc - prev_hs), 8);
                prev_hs     = cyc;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_addr", 32'(bus.res_addr), 32'(e.addr));
                    chk("res_x", 32'(bus.res_x), 32'(e.x));
                    chk("res_y", 32'(bus.res_y), 32'(e.y));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_hs", 32'(cyc - last_hs_cyc), 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input int p, input logic [8:0] ex, input logic [8:0] ey, input bit with_res);
        res_t e;
        addr_q.push_back(24'(p - IMGW));
        addr_q.push_back(24'(p));
        addr_q.push_back(24'(p + IMGW));
        if (with_res) begin
            e.addr = 24'(p); e.x = ex; e.y = ey;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done_and_close(input int d0, input int h0, input bit extra);
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            step();
            start = extra && (done_cnt == d0) && (i % 7 == 3);
        end
        start = 1'b0;
        chk("frame_done_count", 32'(done_cnt - d0), 1);
        chk("frame_results", 32'(hs_count - h0), 3);
        chk("res_q_empty", 32'(exp_q.size()), 0);
        chk("addr_q_empty", 32'(addr_q.size()), 0);
        repeat (3) step();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_no_rd", 32'(bus.mem_rd_en), 0);
    endtask

    task automatic run_frame(input logic [8:0] ex, input logic [8:0] ey, input bit extra);
        int d0, h0;
        d0 = done_cnt; h0 = hs_count; prev_hs = -1;
        for (int p = START; p < END_A; p++) push_pixel(p, ex, ey, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done_and_close(d0, h0, extra);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 0);
        chk({tag, "_mult_en"}, 32'(bus.mult_en), 0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_hold_a"}, 32'(bus.hold_a), 0);
        chk({tag, "_hold_b"}, 32'(bus.hold_b), 0);
        chk({tag, "_hold_c"}, 32'(bus.hold_c), 0);
        chk({tag, "_res_addr"}, 32'(bus.res_addr), 0);
        chk({tag, "_res_x"}, 32'(bus.res_x), 0);
        chk({tag, "_res_y"}, 32'(bus.res_y), 0);
    endtask

    initial begin
        int d0, h0;
        logic [23:0] sa;
        logic [8:0]  sx, sy;

        bus.res_ready = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // Replicated low byte: every row of a window is identical, so both gradients are zero.
        mem_mode = 0;
        run_frame(9'd0, 9'd0, 1'b0);

        mem_mode = 1;
        row_a = 24'h000000; row_b = 24'h000000; row_c = 24'h0A0A0A;
        run_frame(9'd0, 9'd40, 1'b0);

        row_a = 24'h1E0000; row_b = 24'h1E0000; row_c = 24'h1E0000;
        run_frame(9'h188, 9'd0, 1'b0);

        // Gradients beyond 9 bits wrap: -510 -> 0x002, +1020 -> 0x1FC.
        row_a = 24'h000000; row_b = 24'hFF0000; row_c = 24'h000000;
        run_frame(9'h002, 9'd0, 1'b0);
        row_a = 24'h000000; row_b = 24'h000000; row_c = 24'hFFFFFF;
        run_frame(9'd0, 9'h1FC, 1'b0);

        // Stall in OUT with res_ready low.
        row_a = 24'h1E0000; row_b = 24'h1E0000; row_c = 24'h1E0000;
        gap_chk = 1'b0;
        bus.res_ready = 1'b0;
        d0 = done_cnt; h0 = hs_count; prev_hs = -1;
        for (int p = START; p < END_A; p++) push_pixel(p, 9'h188, 9'd0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !bus.res_valid; i++) step();
        chk("stall_valid_seen", 32'(bus.res_valid), 1);
        sa = bus.res_addr; sx = bus.res_x; sy = bus.res_y;
        chk("stall_first_addr", 32'(sa), 32'(START));
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("stall_valid", 32'(bus.res_valid), 1);
            chk("stall_addr", 32'(bus.res_addr), 32'(sa));
            chk("stall_x", 32'(bus.res_x), 32'(sx));
            chk("stall_y", 32'(bus.res_y), 32'(sy));
            chk("stall_no_rd", 32'(bus.mem_rd_en), 0);
        end
        bus.res_ready = 1'b1;
        wait_done_and_close(d0, h0, 1'b0);
        gap_chk = 1'b1;

        // Reset during FEED of the second pixel aborts the frame.
        mem_mode = 0;
        d0 = done_cnt; h0 = hs_count; prev_hs = -1;
        push_pixel(START, 9'd0, 9'd0, 1'b1);
        push_pixel(START + 1, 9'd0, 9'd0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && !(hs_count == h0 + 1 && bus.mult_en); i++) step();
        chk("abort_in_feed2", 32'(bus.mult_en), 1);
        reset = 1'b1;
        step();
        chk_all_zero("abort");
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_addr_q", 32'(addr_q.size()), 0);
        chk("abort_res_q", 32'(exp_q.size()), 0);
        addr_q.delete();
        exp_q.delete();
        run_frame(9'd0, 9'd0, 1'b0);

        // Extra start pulses while busy must be ignored.
        run_frame(9'd0, 9'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
